// File: rtl/bru_redirect_ctrl_pkg.sv
// Shared backend types for branch-resolution and ROB age handling.
//   robIdx_t        : ROB index with wrap flag
//   redirectInfo_t  : {robIdx, npc} pair carried through age pickers
//   rob_is_older    : age compare that respects the wrap flag
package bru_redirect_ctrl_pkg;

  localparam int unsigned XLEN                  = 32;
  localparam int unsigned ROB_IDX_W             = 5;
  localparam int unsigned SQUASH_WINDOW_DEFAULT = 2;

  typedef struct packed {
    logic                 flag;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t         robIdx;
    logic [XLEN-1:0] npc;
  } redirectInfo_t;

  // True when a is strictly older than b. When the flags differ, b has
  // wrapped past a, so the larger raw index is the older one.
  function automatic logic rob_is_older(input robIdx_t a, input robIdx_t b);
    return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/bru_redirect_ctrl_oldest_sel.sv
// Combinational picker: returns the oldest valid {robIdx, npc} entry among
// NUM_IN inputs, plus its lane index. Ties go to the lower lane.
//   i_vld   : per-input valid
//   i_info  : per-input {robIdx, npc}
//   o_vld   : any input valid
//   o_info  : oldest valid entry
//   o_lane  : lane index of o_info
module bru_redirect_ctrl_oldest_sel
  import bru_redirect_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IN = 2,
  localparam int unsigned LaneW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                       [NUM_IN-1:0] i_vld,
  input  redirectInfo_t              [NUM_IN-1:0] i_info,
  output logic                                    o_vld,
  output redirectInfo_t                           o_info,
  output logic                       [LaneW-1:0]  o_lane
);

  always_comb begin
    o_vld  = 1'b0;
    o_info = '0;
    o_lane = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      // Only a strictly older entry displaces the current winner.
      if (i_vld[i] && (!o_vld || rob_is_older(i_info[i].robIdx, o_info.robIdx))) begin
        o_vld  = 1'b1;
        o_info = i_info[i];
        o_lane = LaneW'(i);
      end
    end
  end

endmodule

// File: rtl/bru_redirect_ctrl.sv
// Branch redirect controller: picks the oldest mispredicting resolve each
// cycle, pulses a backend squash and holds a frontend redirect until taken.
//   i_resolve_*      : per-BRU resolve results (valid, robIdx, misPred, npc)
//   i_commit_flush   : global flush, overrides everything
//   o_squash_vld/robIdx : one-cycle squash of everything younger than robIdx
//   o_redirect_vld/pc   : redirect request, held until i_redirect_rdy
//   o_busy           : HOLD state or wrong-path window still open
module bru_redirect_ctrl
  import bru_redirect_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BRU       = 2,
  parameter int unsigned SQUASH_WINDOW = SQUASH_WINDOW_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic    [NUM_BRU-1:0]        i_resolve_vld,
  input  robIdx_t [NUM_BRU-1:0]        i_resolve_robIdx,
  input  logic    [NUM_BRU-1:0]        i_resolve_misPred,
  input  logic    [NUM_BRU-1:0][XLEN-1:0] i_resolve_npc,
  input  logic                         i_commit_flush,
  output logic                         o_squash_vld,
  output robIdx_t                      o_squash_robIdx,
  output logic                         o_redirect_vld,
  output logic    [XLEN-1:0]           o_redirect_pc,
  input  logic                         i_redirect_rdy,
  output logic                         o_busy
);

  localparam int unsigned LaneW = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;
  localparam int unsigned WcntW = $clog2(SQUASH_WINDOW + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]      state_d, state_q;
  logic [WcntW-1:0] wcnt_d, wcnt_q;
  logic            squash_vld_d, squash_vld_q;
  robIdx_t         squash_idx_d, squash_idx_q;
  logic            redirect_vld_d, redirect_vld_q;
  logic [XLEN-1:0] redirect_pc_d, redirect_pc_q;
  logic            busy_d, busy_q;

  logic          [NUM_BRU-1:0] lane_vld;
  redirectInfo_t [NUM_BRU-1:0] lane_info;
  logic                        sel_vld;
  redirectInfo_t               sel_info;
  logic          [LaneW-1:0]   sel_lane;
  logic                        unused_sel_lane;
  logic                        need_older;
  logic                        cand;

  always_comb begin
    lane_vld  = i_resolve_vld & i_resolve_misPred;
    lane_info = '0;
    for (int unsigned i = 0; i < NUM_BRU; i++) begin
      lane_info[i].robIdx = i_resolve_robIdx[i];
      lane_info[i].npc    = i_resolve_npc[i];
    end
  end

  bru_redirect_ctrl_oldest_sel #(
    .NUM_IN (NUM_BRU)
  ) u_oldest_sel (
    .i_vld  (lane_vld),
    .i_info (lane_info),
    .o_vld  (sel_vld),
    .o_info (sel_info),
    .o_lane (sel_lane)
  );

  assign unused_sel_lane = ^sel_lane;

  // The last squashed robIdx doubles as the pending entry in HOLD and as the
  // wrong-path reference while the window is open. If the oldest lane is not
  // older than it, no other lane can be either.
  assign need_older = (state_q == StHold) || (wcnt_q != '0);
  assign cand = sel_vld && (!need_older || rob_is_older(sel_info.robIdx, squash_idx_q));

  always_comb begin
    state_d        = state_q;
    wcnt_d         = (wcnt_q != '0) ? wcnt_q - WcntW'(1) : wcnt_q;
    squash_vld_d   = 1'b0;
    squash_idx_d   = squash_idx_q;
    redirect_vld_d = redirect_vld_q;
    redirect_pc_d  = redirect_pc_q;

    if (i_commit_flush) begin
      state_d        = StIdle;
      wcnt_d         = '0;
      redirect_vld_d = 1'b0;
      squash_idx_d   = '0;
      redirect_pc_d  = '0;
    end else if (cand) begin
      // New or replacing mispredict; wins even over a same-cycle handshake.
      state_d        = StHold;
      wcnt_d         = WcntW'(SQUASH_WINDOW);
      squash_vld_d   = 1'b1;
      squash_idx_d   = sel_info.robIdx;
      redirect_vld_d = 1'b1;
      redirect_pc_d  = sel_info.npc;
    end else if ((state_q == StHold) && i_redirect_rdy) begin
      state_d        = StIdle;
      redirect_vld_d = 1'b0;
    end

    busy_d = (state_d == StHold) || (wcnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      wcnt_q         <= '0;
      squash_vld_q   <= 1'b0;
      squash_idx_q   <= '0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      squash_vld_q   <= squash_vld_d;
      squash_idx_q   <= squash_idx_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
      busy_q         <= busy_d;
    end
  end

  assign o_squash_vld    = squash_vld_q;
  assign o_squash_robIdx = squash_idx_q;
  assign o_redirect_vld  = redirect_vld_q;
  assign o_redirect_pc   = redirect_pc_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_bru_redirect_ctrl.sv
// Directed self-checking bench for bru_redirect_ctrl (ROB of 32, 2 lanes).
module tb_bru_redirect_ctrl;
  import bru_redirect_ctrl_pkg::*;

  localparam int unsigned NUM_BRU = 2;

  logic                            clk;
  logic                            rst;
  logic    [NUM_BRU-1:0]           vld;
  robIdx_t [NUM_BRU-1:0]           rob;
  logic    [NUM_BRU-1:0]           mp;
  logic    [NUM_BRU-1:0][XLEN-1:0] npc;
  logic                            flush;
  logic                            sq_vld;
  logic    [5:0]                   sq_idx;
  logic                            rd_vld;
  logic    [XLEN-1:0]              rd_pc;
  logic                            rdy;
  logic                            busy;

  int n_cmp;
  int n_bad;

  bru_redirect_ctrl #(
    .NUM_BRU       (NUM_BRU),
    .SQUASH_WINDOW (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_resolve_vld     (vld),
    .i_resolve_robIdx  (rob),
    .i_resolve_misPred (mp),
    .i_resolve_npc     (npc),
    .i_commit_flush    (flush),
    .o_squash_vld      (sq_vld),
    .o_squash_robIdx   (sq_idx),
    .o_redirect_vld    (rd_vld),
    .o_redirect_pc     (rd_pc),
    .i_redirect_rdy    (rdy),
    .o_busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    vld = '0;
    mp  = '0;
    rob = '0;
    npc = '0;
  endtask

  task automatic set_lane(input int l, input logic f, input logic [4:0] idx,
                          input logic [31:0] pc, input logic misp);
    vld[l] = 1'b1;
    mp[l]  = misp;
    rob[l] = {f, idx};
    npc[l] = pc;
  endtask

  task automatic check_out(input string tag, input logic e_sq, input logic [5:0] e_idx,
                           input logic e_rd, input logic [31:0] e_pc, input logic e_busy);
    check_eq({tag, ".squash_vld"}, 64'(sq_vld), 64'(e_sq));
    check_eq({tag, ".squash_idx"}, 64'(sq_idx), 64'(e_idx));
    check_eq({tag, ".redirect_vld"}, 64'(rd_vld), 64'(e_rd));
    check_eq({tag, ".redirect_pc"}, 64'(rd_pc), 64'(e_pc));
    check_eq({tag, ".busy"}, 64'(busy), 64'(e_busy));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    flush = 1'b0;
    rdy   = 1'b1;
    clear_lanes();
    tick();
    check_out("reset", 1'b0, 6'h00, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;

    // Non-mispredicted resolve must not start anything.
    set_lane(0, 1'b0, 5'd4, 32'h8000_0040, 1'b0);
    tick();
    clear_lanes();
    check_out("no_mispred", 1'b0, 6'h00, 1'b0, 32'h0, 1'b0);

    // 1: single mispredict, frontend ready.
    set_lane(0, 1'b0, 5'd5, 32'h8000_0100, 1'b1);
    tick();
    clear_lanes();
    check_out("t1.pulse", 1'b1, 6'h05, 1'b1, 32'h8000_0100, 1'b1);
    tick();
    check_out("t1.accepted", 1'b0, 6'h05, 1'b0, 32'h8000_0100, 1'b1);
    tick();
    check_eq("t1.window_done", 64'(busy), 64'd0);

    // 2: two lanes at once, lane1 is older.
    set_lane(0, 1'b0, 5'd9, 32'h0000_0900, 1'b1);
    set_lane(1, 1'b0, 5'd7, 32'h0000_0700, 1'b1);
    tick();
    clear_lanes();
    check_out("t2.pulse", 1'b1, 6'h07, 1'b1, 32'h0000_0700, 1'b1);
    tick();
    check_out("t2.accepted", 1'b0, 6'h07, 1'b0, 32'h0000_0700, 1'b1);
    tick();
    check_eq("t2.idle", 64'(busy), 64'd0);

    // 3: wrap-around age compare while holding.
    rdy = 1'b0;
    set_lane(0, 1'b0, 5'd30, 32'h0000_3000, 1'b1);
    tick();
    clear_lanes();
    check_out("t3.pulse30", 1'b1, 6'h1E, 1'b1, 32'h0000_3000, 1'b1);
    tick();
    tick();
    set_lane(1, 1'b1, 5'd2, 32'h0000_1200, 1'b1);
    tick();
    clear_lanes();
    check_out("t3.younger_ignored", 1'b0, 6'h1E, 1'b1, 32'h0000_3000, 1'b1);
    set_lane(0, 1'b0, 5'd28, 32'h0000_2800, 1'b1);
    tick();
    clear_lanes();
    check_out("t3.replace28", 1'b1, 6'h1C, 1'b1, 32'h0000_2800, 1'b1);

    // 4: back-pressure keeps the request stable.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t4.stall", 1'b0, 6'h1C, 1'b1, 32'h0000_2800, 1'b1);
    end
    rdy = 1'b1;
    set_lane(1, 1'b0, 5'd20, 32'h0000_2000, 1'b1);
    tick();
    clear_lanes();
    check_out("t4.replace_on_hs", 1'b1, 6'h14, 1'b1, 32'h0000_2000, 1'b1);
    tick();
    check_out("t4.accepted", 1'b0, 6'h14, 1'b0, 32'h0000_2000, 1'b1);
    tick();
    check_eq("t4.idle", 64'(busy), 64'd0);

    // 5: wrong-path drop inside the window, accept after it closes.
    set_lane(0, 1'b0, 5'd10, 32'h0000_0A00, 1'b1);
    tick();
    clear_lanes();
    check_out("t5.pulse10", 1'b1, 6'h0A, 1'b1, 32'h0000_0A00, 1'b1);
    set_lane(1, 1'b0, 5'd12, 32'h0000_0C00, 1'b1);
    tick();
    clear_lanes();
    check_out("t5.dropped", 1'b0, 6'h0A, 1'b0, 32'h0000_0A00, 1'b1);
    tick();
    check_eq("t5.window_closed", 64'(busy), 64'd0);
    set_lane(1, 1'b0, 5'd12, 32'h0000_0C00, 1'b1);
    tick();
    clear_lanes();
    check_out("t5.accept12", 1'b1, 6'h0C, 1'b1, 32'h0000_0C00, 1'b1);
    tick();
    tick();

    // 6: flush in HOLD beats a simultaneous mispredict; async reset in HOLD.
    rdy = 1'b0;
    set_lane(0, 1'b0, 5'd15, 32'h0000_0F00, 1'b1);
    tick();
    clear_lanes();
    check_out("t6.hold", 1'b1, 6'h0F, 1'b1, 32'h0000_0F00, 1'b1);
    flush = 1'b1;
    set_lane(0, 1'b0, 5'd3, 32'h0000_0300, 1'b1);
    tick();
    flush = 1'b0;
    clear_lanes();
    check_out("t6.flushed", 1'b0, 6'h00, 1'b0, 32'h0, 1'b0);
    tick();
    check_out("t6.after_flush", 1'b0, 6'h00, 1'b0, 32'h0, 1'b0);
    set_lane(0, 1'b0, 5'd15, 32'h0000_0F00, 1'b1);
    tick();
    clear_lanes();
    check_eq("t6.rehold", 64'(rd_vld), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_out("t6.async_rst", 1'b0, 6'h00, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bru_redirect_ctrl.md
Name: bru_redirect_ctrl

Overview:
- Collects branch/jump resolution results from NUM_BRU misc/branch execution units each cycle.
- Selects the oldest mispredicted instruction and issues one squash pulse to the backend.
- Holds a redirect request to the frontend until it is accepted, replacing it if an older mispredict arrives first.
- Sits between the misc FUs and the frontend/ROB flush network.

Parameters:
- NUM_BRU, 2, number of branch-resolving FUs reporting per cycle.
- SQUASH_WINDOW, 2, cycles after a squash pulse during which younger resolves are dropped as wrong-path.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_resolve_vld  in  NUM_BRU  per-FU resolve valid
- i_resolve_robIdx  in  robIdx_t[NUM_BRU]  ROB index of the resolving instruction, with wrap flag
- i_resolve_misPred  in  NUM_BRU  resolve was mispredicted
- i_resolve_npc  in  XLEN[NUM_BRU]  correct next PC
- i_commit_flush  in  1  global flush (exception/interrupt); highest priority
- o_squash_vld  out  1  one-cycle pulse; kill everything younger than o_squash_robIdx
- o_squash_robIdx  out  robIdx_t  oldest surviving mispredict
- o_redirect_vld  out  1  redirect request to the frontend
- o_redirect_pc  out  XLEN  redirect target
- i_redirect_rdy  in  1  frontend accepts the redirect
- o_busy  out  1  state != IDLE or window counter != 0

Behaviour:
- All outputs are registered.
- Reset values: o_squash_vld=0, o_redirect_vld=0, o_squash_robIdx=0, o_redirect_pc=0, o_busy=0, state=IDLE, wcnt=0, pending_vld=0.

Age rule:
- older(a,b) = (a.flag==b.flag) ? a.idx<b.idx : a.idx>b.idx.
- Equal robIdx counts as not older.

Candidate and latency:
- Candidate = oldest lane with vld & misPred.
- A lane is dropped if wcnt!=0 and it is not older than the last squashed robIdx.
- Latency: a candidate accepted in cycle T drives o_squash_vld=1 and o_redirect_vld=1 in T+1.

State machine:
- IDLE:
  - Candidate present → latch robIdx/npc, pulse squash, go to HOLD, load wcnt=SQUASH_WINDOW.
- HOLD:
  - Hold o_redirect_vld=1 with a stable pc until i_redirect_rdy.
  - An older candidate replaces the pending one: re-latch, re-pulse squash, reload wcnt, stay in HOLD. This applies even if the handshake completes in the same cycle.
  - A candidate not older than the pending one is ignored.
  - Handshake with no older candidate → IDLE next cycle; the pending robIdx stays as the drop reference while wcnt!=0.

Window counter:
- wcnt decrements in any state while nonzero.
- While wcnt!=0, a candidate not older than the reference robIdx is dropped.
- An older candidate after a handshake behaves as in IDLE (new squash, new HOLD).

Flush and reset:
- i_commit_flush (any state): next cycle state=IDLE, wcnt=0, o_redirect_vld=0, o_squash_vld=0.
- All resolves in the flush cycle are ignored.
- Asserting rst mid-HOLD drops the request immediately (asynchronous).
- Non-mispredict resolves never affect state.
- o_squash_vld is never high two consecutive cycles unless a strictly older candidate arrives.

Decomposition:
- Shared backend package:
  - robIdx_t (existing)
  - function rob_is_older(a,b)
  - redirectInfo_t struct {robIdx, npc}
  - SQUASH_WINDOW default constant
- Sub-module oldest_sel (NUM_BRU-input reduction tree of {vld, robIdx, npc}):
  - outputs the oldest valid entry and its lane index
  - purely combinational, reused by the ROB exception picker

Test Plan (ROB = 32 entries; robIdx written flag:idx):
1. Single mispredict, lane0 robIdx 0:5, npc 0x8000_0100, rdy=1 → T+1 squash pulse 0:5 and redirect_vld with pc 0x8000_0100; T+2 redirect_vld=0, o_busy=1 until wcnt expires.
2. Simultaneous lanes: lane0 0:9 and lane1 0:7, both mispredicted → squash 0:7, pc from lane1; lane0 never redirected.
3. Wrap-around: pending 0:30 with rdy=0; new mispredict 1:2 arrives → ignored (younger). Then 0:28 arrives → replaces, second squash pulse with 0:28.
4. Back-pressure: rdy=0 for 5 cycles → redirect_vld and pc stable; rdy=1 in the same cycle an older mispredict arrives → the older one becomes pending, redirect_vld stays 1.
5. Wrong-path drop: squash 0:10 accepted; next cycle lane1 mispredict 0:12 → dropped, no pulse. With wcnt=0, mispredict 0:12 → accepted.
6. i_commit_flush during HOLD with a simultaneous lane0 mispredict 0:3 → next cycle all outputs 0, state IDLE; asynchronous rst mid-HOLD clears outputs immediately.
